coproc_cmd_sequencer: RTL
=========================

Name: coproc_cmd_sequencer

Overview:
- Parametrised command queue and dispatcher placed between the CPU's memory-mapped coprocessor interface and coproc.
- The CPU pushes commands (func, gray, img_idx). The block buffers them, issues each with a one-cycle start pulse once coproc is ready, and holds the operands stable until done.
- Adds a watchdog timeout, a programmable inter-command gap, a queue flush and completion accounting. Software therefore no longer busy-waits per command.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- FUNC_W, 3, width of the func field.
- IDX_W, 1, width of the img_idx field; selects one of 2^IDX_W image buffers.
- TIMEOUT, 100000, maximum cycles from start to done before abort; at least 2.
- GAP_W, 8, width of the inter-command gap setting.
- CNT_W, 16, width of the completion and abort counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  CPU offers a command
- cmd_ready  out  1  queue can accept; equals !full
- cmd_func  in  FUNC_W  command function code
- cmd_gray  in  1  grayscale mode flag
- cmd_img_idx  in  IDX_W  source image buffer
- flush  in  1  one-cycle pulse; discards queued, not-yet-issued commands
- gap_cycles  in  GAP_W  idle cycles inserted after each completion
- co_rdy  in  1  coproc ready for a new start
- co_done  in  1  coproc finished; single-cycle pulse
- start  out  1  one-cycle start pulse to coproc
- func  out  FUNC_W  held operand to coproc
- gray  out  1  held operand to coproc
- img_idx  out  IDX_W  held operand to coproc
- busy  out  1  high in any state other than IDLE, or while the queue is non-empty
- q_count  out  $clog2(DEPTH)+1  current queue occupancy
- timeout_err  out  1  sticky abort flag
- err_clr  in  1  clears timeout_err
- done_count  out  CNT_W  completed commands, wraps
- abort_count  out  CNT_W  timed-out commands, saturates

Behaviour:
- Reset values: all outputs 0 and queue empty, except cmd_ready=1. State is IDLE.
- Reset asserted mid-operation aborts immediately:
  - start drops within the reset.
  - The in-flight command is lost and not counted.
- Push occurs when cmd_valid && cmd_ready on a rising edge. A push while full is impossible by construction.
- Pop occurs on the ISSUE cycle. Push and pop in the same cycle leave q_count unchanged.
- The FSM has four states:
  - IDLE: when the queue is non-empty && co_rdy, go to ISSUE.
  - ISSUE (1 cycle): start=1; func/gray/img_idx load from the FIFO head; watchdog cleared; go to WAIT.
  - WAIT: counts cycles.
    - co_done: done_count+1, go to GAP.
    - Watchdog reaches TIMEOUT with no done: timeout_err=1, abort_count+1 (saturating), go to GAP.
  - GAP: counts gap_cycles idle cycles, then returns to IDLE. gap_cycles=0 means GAP lasts 0 cycles and the FSM returns to IDLE in the same transition.
- Latency:
  - With a non-empty queue and co_rdy already high, start asserts in the cycle after entering IDLE.
  - A command pushed into an empty idle queue produces start 2 cycles after the push edge.
- func/gray/img_idx stay stable from ISSUE until the next ISSUE.
- co_done outside WAIT is ignored.
- co_done in the same cycle the watchdog expires counts as completion, not abort.
- flush:
  - Clears the FIFO pointers; q_count=0 next cycle.
  - The command in WAIT/GAP completes normally.
  - flush coincident with a push: flush wins and the pushed command is discarded.
  - flush coincident with ISSUE: the issuing command proceeds; the remaining entries are dropped.
- err_clr clears timeout_err. If err_clr coincides with a new timeout, the set wins.
- FIFO pointers wrap modulo DEPTH. q_count ranges 0..DEPTH.

Test Plan:
- Single command: push func=3'b111, gray=0, idx=0 with co_rdy=1. Expect:
  - start pulses for exactly 1 cycle, 2 cycles after the push.
  - func=7 held.
  - co_done after 50 cycles gives done_count=1; busy drops after gap_cycles+1.
- Fill and back-pressure: DEPTH=4, push 5 commands while co_rdy=0. Expect cmd_ready=0 after the 4th, q_count=4, and the 5th not accepted. Then raise co_rdy and drive 4 done pulses. Expect 4 starts in FIFO order (010, 110, 011, 111) and done_count=4.
- Gap timing: gap_cycles=10 with two queued commands. Expect the second start to occur exactly 12 cycles after the first co_done.
- Timeout: TIMEOUT=100, never assert co_done. Expect:
  - timeout_err=1 at start+100 and abort_count=1.
  - The next queued command then issues.
  - err_clr returns timeout_err to 0.
- Flush mid-run: 3 queued, one in WAIT; pulse flush. Expect q_count=0 and no further start after the in-flight done; done_count increments by 1 only.
- Async reset during WAIT: drive rst_n=0 between clock edges. Expect start, busy, q_count and done_count at 0 immediately, and cmd_ready=1.

Source files
------------

// File: rtl/coproc_cmd_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// coproc_cmd_sequencer
//
// Command queue and dispatcher between the CPU's memory-mapped coprocessor
// interface and the coprocessor. The CPU pushes (func, gray, img_idx) commands
// into a small FIFO. Each command is issued with a one-cycle start pulse once
// the coprocessor reports ready. Its operands are then held stable until the
// next issue.
//
// A watchdog aborts a command that never signals done. A programmable idle gap
// follows every completion or abort. A flush discards queued, not-yet-issued
// commands. Completions and aborts are counted.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  push handshake (cmd_ready == !full)
//   cmd_func/gray/idx    command fields captured on push
//   flush                one-cycle pulse, empties the queue
//   gap_cycles           idle cycles inserted after each command ends
//   co_rdy, co_done      coprocessor ready level and done pulse
//   start                one-cycle start pulse to the coprocessor
//   func/gray/img_idx    operands held from one issue to the next
//   busy                 sequencer not idle, or queue non-empty
//   q_count              queue occupancy, 0..DEPTH
//   timeout_err, err_clr sticky watchdog abort flag and its clear
//   done_count           completed commands (wraps)
//   abort_count          timed-out commands (saturates)
// -----------------------------------------------------------------------------
module coproc_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FUNC_W  = 3,
  parameter int unsigned IDX_W   = 1,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FUNC_W-1:0]      cmd_func,
  input  logic                   cmd_gray,
  input  logic [IDX_W-1:0]       cmd_img_idx,
  input  logic                   flush,
  input  logic [GAP_W-1:0]       gap_cycles,
  input  logic                   co_rdy,
  input  logic                   co_done,
  output logic                   start,
  output logic [FUNC_W-1:0]      func,
  output logic                   gray,
  output logic [IDX_W-1:0]       img_idx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       done_count,
  output logic [CNT_W-1:0]       abort_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned EW   = FUNC_W + 1 + IDX_W;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]       FullCnt  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]       PtrOne   = (AW + 1)'(1);
  localparam logic [WD_W-1:0]   WdLast   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]   WdOne    = WD_W'(1);
  localparam logic [GAP_W-1:0]  GapOne   = GAP_W'(1);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StGap
  } state_e;

  state_e state;

  // ---------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;
  logic [EW-1:0] head;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FullCnt);
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign q_count   = count;
  assign head      = mem[rd_ptr[AW-1:0]];

  // A flush in the same cycle as a push discards the pushed command too.
  assign push  = cmd_valid & ~full & ~flush;
  // The head is popped on the edge that moves the FSM into its issue cycle.
  assign issue = (state == StIdle) & ~empty & co_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_func, cmd_gray, cmd_img_idx};
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM with registered outputs.
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0]  wd;
  logic [GAP_W-1:0] gap_left;
  logic             wd_expired;
  logic             cmd_end;

  // The watchdog is 0 in the issue cycle and counts one per cycle after it,
  // so expiry lands exactly TIMEOUT cycles after start rose.
  assign wd_expired = (wd == WdLast);
  assign cmd_end    = (state == StWait) & (co_done | wd_expired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      start       <= 1'b0;
      func        <= '0;
      gray        <= 1'b0;
      img_idx     <= '0;
      wd          <= '0;
      gap_left    <= '0;
      timeout_err <= 1'b0;
      done_count  <= '0;
      abort_count <= '0;
    end else begin
      start <= 1'b0;
      // A timeout set below overrides this clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (issue) begin
            state                  <= StIssue;
            start                  <= 1'b1;
            {func, gray, img_idx}  <= head;
            wd                     <= '0;
          end
        end

        StIssue: begin
          state <= StWait;
          wd    <= wd + WdOne;
        end

        StWait: begin
          // A done arriving on the expiry cycle still counts as a completion.
          if (co_done) begin
            done_count <= done_count + CntOne;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            if (abort_count != CntMax) begin
              abort_count <= abort_count + CntOne;
            end
          end else begin
            wd <= wd + WdOne;
          end

          if (cmd_end) begin
            if (gap_cycles == '0) begin
              state <= StIdle;
            end else begin
              state    <= StGap;
              gap_left <= gap_cycles - GapOne;
            end
          end
        end

        StGap: begin
          if (gap_left == '0) begin
            state <= StIdle;
          end else begin
            gap_left <= gap_left - GapOne;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state != StIdle) | ~empty;

endmodule
